keyboard_key_tracker: RTL and testbench
=======================================

# keyboard_key_tracker

Converts the PS/2 scan-code byte stream (set 2) into the per-key control levels and pulses consumed by the game state machine (`rightArrow`, `leftArrow`, `spaceBar`). It sits directly upstream of the game state machine, fed by the PS/2 byte receiver. It tracks make/break prefixes across bytes, holds arrow keys as levels, and converts space into a single-cycle press pulse. The pulse suppresses typematic repeats, so that holding space cannot skip through welcome, play and game-over screens.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: idle cycles after a prefix byte before the tracker abandons the sequence (20 ms at 50 MHz). Must be ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  one clock; reset is asynchronous and active-high.
- `din_new`  in  1  single-cycle strobe; `din` is valid this cycle.
- `din`  in  8  received scan-code byte.
- `rightArrow`  out  1  level: right arrow held.
- `leftArrow`  out  1  level: left arrow held.
- `spaceBar`  out  1  one-cycle pulse on a fresh space press.
- `spaceHeld`  out  1  level: space held.
- `protoErr`  out  1  one-cycle pulse on timeout or an illegal byte after a prefix.

## Operation
- Scan codes: EXT = E0, BRK = F0, SPACE = 29, RIGHT = E0-prefixed 74, LEFT = E0-prefixed 6B.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Bytes are acted on only in cycles where `din_new` = 1.
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - 29 → space make, stay in IDLE.
  - Any other byte is ignored; stay in IDLE.
- EXT:
  - F0 → EXT_BRK.
  - 74 → set `rightArrow`.
  - 6B → set `leftArrow`.
  - E0 → stay in EXT.
  - Any other byte is ignored (other extended keys, no error) → IDLE.
- BRK:
  - 29 → clear `spaceHeld`.
  - F0 → stay in BRK.
  - E0 → pulse `protoErr`.
  - All of these except F0 → IDLE.
  - Any other byte is ignored → IDLE.
- EXT_BRK:
  - 74 → clear `rightArrow`.
  - 6B → clear `leftArrow`.
  - E0 or F0 → pulse `protoErr`.
  - All cases → IDLE.
- Space make:
  - If `spaceHeld` = 0: set `spaceHeld` and pulse `spaceBar`.
  - If `spaceHeld` = 1 (typematic repeat): no pulse.
- Both arrows may be held together; both levels are reported as-is, with no arbitration.
- Timeout counter:
  - Cleared on every `din_new`, and whenever the state is IDLE.
  - Increments each cycle in a non-IDLE state.
  - On reaching TIMEOUT_CYCLES−1 the FSM returns to IDLE and `protoErr` pulses. Held levels are unchanged.
- Width: counter is $clog2(TIMEOUT_CYCLES) bits. Saturation is not required, because reaching the limit forces IDLE.

## Timing
- All outputs are registered. An effect appears in the cycle after the `din_new` cycle: latency 1.
- `spaceBar` and `protoErr` are high for exactly one cycle.
- Back-to-back `din_new` on consecutive cycles is legal and every byte is processed.
- If `din_new` and timeout expiry fall in the same cycle, the byte wins: it is processed in the current state, and there is no `protoErr` for the timeout.
- Reset, asserted asynchronously at any time, including mid-sequence:
  - state = IDLE, counter = 0.
  - All outputs = 0.
  - A partial prefix sequence is discarded.
- The first byte after reset deassertion is decoded from IDLE.

## Structure
- Package `kbd_pkg` holds:
  - Scan-code constants: `KBD_EXT` = 8'hE0, `KBD_BRK` = 8'hF0, `KBD_SPACE` = 8'h29, `KBD_RIGHT` = 8'h74, `KBD_LEFT` = 8'h6B.
  - The FSM state enum `kbd_state_t`.
- One sub-module, `prefix_timeout`, is natural. It holds the counter with `clear`/`run` inputs and an `expired` pulse output, and is parameterised by TIMEOUT_CYCLES.
- Everything else is in the top module: the FSM plus output registers.

## Test plan
- Bytes E0, 74 → `rightArrow` = 1 one cycle after the 74 strobe. Then E0, F0, 74 → `rightArrow` = 0; `leftArrow` stays 0 throughout.
- Space typematic: 29, 29, 29 → one `spaceBar` pulse and `spaceHeld` = 1. Then F0, 29 → `spaceHeld` = 0. A following 29 → a second `spaceBar` pulse.
- Both arrows: E0 6B, E0 74 → both levels = 1. Then E0 F0 6B → only `leftArrow` = 0.
- Timeout with TIMEOUT_CYCLES = 8:
  - E0, then no strobe for 8 cycles → `protoErr` pulse and state IDLE.
  - A following 74 (no prefix) is ignored: `rightArrow` stays 0.
  - Separately, a byte strobed on the expiry cycle is processed with no `protoErr`.
- Illegal bytes: E0 F0 F0 → `protoErr` pulse and return to IDLE. F0 E0 → `protoErr` pulse.
- Reset: assert reset between E0 and 74 while `leftArrow` = 1 → all outputs 0 immediately. After release, byte 74 → no change.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg
//   Shared definitions for the PS/2 (scan-code set 2) key tracker:
//   scan-code byte constants and the prefix-tracking FSM state type.
package kbd_pkg;

  localparam logic [7:0] KBD_EXT   = 8'hE0;  // extended-key prefix
  localparam logic [7:0] KBD_BRK   = 8'hF0;  // break (release) prefix
  localparam logic [7:0] KBD_SPACE = 8'h29;
  localparam logic [7:0] KBD_RIGHT = 8'h74;  // only meaningful after E0
  localparam logic [7:0] KBD_LEFT  = 8'h6B;  // only meaningful after E0

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_t;

endpackage

// File: rtl/keyboard_key_tracker_prefix_timeout.sv
// prefix_timeout
//   Idle-cycle counter that bounds how long the tracker may sit part-way
//   through a prefixed scan-code sequence.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clear       zero the counter this cycle (byte arrived, or tracker idle)
//   run         count this cycle (tracker is inside a prefix sequence)
//   expired     combinational: counter is at TIMEOUT_CYCLES-1 while running
//               and no clear is pending, i.e. the sequence is abandoned now
module prefix_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // No saturation: reaching LIMIT forces the FSM back to idle, which then
  // clears the counter, so any wrap on the expiry edge is harmless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Gating with clear makes a byte arriving on the expiry cycle win.
  assign expired = run && !clear && (cnt_q == LIMIT);

endmodule

// File: rtl/keyboard_key_tracker.sv
// keyboard_key_tracker
//   Turns the PS/2 set-2 byte stream into key levels/pulses for the game
//   state machine. Tracks E0/F0 prefixes across bytes, holds arrow keys as
//   levels, and turns space into a single press pulse that ignores
//   typematic repeats.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   din_new      single-cycle strobe: din valid this cycle. There is no
//                back-pressure: every strobed byte is consumed that cycle.
//   din[7:0]     received scan-code byte
//   rightArrow   level: right arrow held
//   leftArrow    level: left arrow held
//   spaceBar     one-cycle pulse on a fresh space press
//   spaceHeld    level: space held
//   protoErr     one-cycle pulse on prefix timeout or illegal byte after prefix
// All outputs are registered; effects appear the cycle after the strobe.
module keyboard_key_tracker
  import kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din_new,
  input  logic [7:0] din,
  output logic       rightArrow,
  output logic       leftArrow,
  output logic       spaceBar,
  output logic       spaceHeld,
  output logic       protoErr
);

  kbd_state_t state_q, state_d;
  logic right_q, right_d;
  logic left_q, left_d;
  logic held_q, held_d;
  logic press_q, press_d;
  logic err_q, err_d;
  logic expired;

  prefix_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (din_new || (state_q == ST_IDLE)),
    .run    (state_q != ST_IDLE),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      right_q <= 1'b0;
      left_q  <= 1'b0;
      held_q  <= 1'b0;
      press_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      right_q <= right_d;
      left_q  <= left_d;
      held_q  <= held_d;
      press_q <= press_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    right_d = right_q;
    left_d  = left_q;
    held_d  = held_q;
    press_d = 1'b0;
    err_d   = 1'b0;

    if (din_new) begin
      unique case (state_q)
        ST_IDLE: begin
          if (din == KBD_EXT) begin
            state_d = ST_EXT;
          end else if (din == KBD_BRK) begin
            state_d = ST_BRK;
          end else if (din == KBD_SPACE) begin
            // A make while already held is a typematic repeat: no pulse.
            if (!held_q) begin
              held_d  = 1'b1;
              press_d = 1'b1;
            end
          end
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (din == KBD_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (din == KBD_EXT) begin
            state_d = ST_EXT;
          end else if (din == KBD_RIGHT) begin
            right_d = 1'b1;
          end else if (din == KBD_LEFT) begin
            left_d = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (din == KBD_BRK) begin
            state_d = ST_BRK;
          end else if (din == KBD_SPACE) begin
            held_d = 1'b0;
          end else if (din == KBD_EXT) begin
            err_d = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (din == KBD_RIGHT) begin
            right_d = 1'b0;
          end else if (din == KBD_LEFT) begin
            left_d = 1'b0;
          end else if ((din == KBD_EXT) || (din == KBD_BRK)) begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expired) begin
      // Abandon the partial sequence; held levels are left alone.
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
  end

  assign rightArrow = right_q;
  assign leftArrow  = left_q;
  assign spaceBar   = press_q;
  assign spaceHeld  = held_q;
  assign protoErr   = err_q;

endmodule

// File: tb/tb_keyboard_key_tracker.sv
// tb_keyboard_key_tracker
//   Directed scan-code sequences with hand-computed expected output vectors.
//   Output vector bit order: {rightArrow, leftArrow, spaceBar, spaceHeld, protoErr}.
module tb_keyboard_key_tracker;

  logic       clk;
  logic       reset;
  logic       din_new;
  logic [7:0] din;
  logic       rightArrow, leftArrow, spaceBar, spaceHeld, protoErr;

  logic [4:0] exp_q[$];
  string      name_q[$];
  int         n_pass;
  int         n_total;
  bit         drive_done;

  keyboard_key_tracker #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din_new   (din_new),
    .din       (din),
    .rightArrow(rightArrow),
    .leftArrow (leftArrow),
    .spaceBar  (spaceBar),
    .spaceHeld (spaceHeld),
    .protoErr  (protoErr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {rightArrow, leftArrow, spaceBar, spaceHeld, protoErr};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got {R,L,S,H,E}=%b expected %b at %0t", name, got, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1. Applies one cycle of input, then queues the output
  // vector expected after that edge.
  task automatic step(input string name, input logic v, input logic [7:0] b,
                      input logic [4:0] e);
    din_new = v;
    din     = b;
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(name);
    #1;
    din_new = 1'b0;
    din     = 8'h00;
  endtask

  task automatic byte_in(input string name, input logic [7:0] b, input logic [4:0] e);
    step(name, 1'b1, b, e);
  endtask

  task automatic idle(input string name, input logic [4:0] e);
    step(name, 1'b0, 8'h00, e);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        logic [4:0] e;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, outs(), e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_pass     = 0;
    n_total    = 0;
    drive_done = 1'b0;
    reset      = 1'b1;
    din_new    = 1'b0;
    din        = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), 5'b00000);
    reset = 1'b0;
    idle("post_reset_idle", 5'b00000);

    // Right arrow make / break; left stays 0.
    byte_in("right_e0",       8'hE0, 5'b00000);
    byte_in("right_make",     8'h74, 5'b10000);
    byte_in("right_brk_e0",   8'hE0, 5'b10000);
    byte_in("right_brk_f0",   8'hF0, 5'b10000);
    byte_in("right_break",    8'h74, 5'b00000);

    // Space typematic suppression.
    byte_in("space_make1",    8'h29, 5'b00110);
    byte_in("space_rep2",     8'h29, 5'b00010);
    byte_in("space_rep3",     8'h29, 5'b00010);
    byte_in("space_brk_f0",   8'hF0, 5'b00010);
    byte_in("space_break",    8'h29, 5'b00000);
    byte_in("space_make2",    8'h29, 5'b00110);
    idle("space_pulse_end",         5'b00010);
    byte_in("space_brk2_f0",  8'hF0, 5'b00010);
    byte_in("space_break2",   8'h29, 5'b00000);

    // Both arrows held, release only left.
    byte_in("both_e0a",       8'hE0, 5'b00000);
    byte_in("left_make",      8'h6B, 5'b01000);
    byte_in("both_e0b",       8'hE0, 5'b01000);
    byte_in("both_right",     8'h74, 5'b11000);
    byte_in("lbrk_e0",        8'hE0, 5'b11000);
    byte_in("lbrk_f0",        8'hF0, 5'b11000);
    byte_in("left_break",     8'h6B, 5'b10000);
    byte_in("rbrk_e0",        8'hE0, 5'b10000);
    byte_in("rbrk_f0",        8'hF0, 5'b10000);
    byte_in("right_break2",   8'h74, 5'b00000);

    // Repeated E0 stays in EXT; an unknown extended key returns to IDLE.
    byte_in("ext_e0a",        8'hE0, 5'b00000);
    byte_in("ext_e0b",        8'hE0, 5'b00000);
    byte_in("ext_e0_right",   8'h74, 5'b10000);
    byte_in("ext_rel_e0",     8'hE0, 5'b10000);
    byte_in("ext_rel_f0",     8'hF0, 5'b10000);
    byte_in("ext_rel_74",     8'h74, 5'b00000);
    byte_in("ext_unk_e0",     8'hE0, 5'b00000);
    byte_in("ext_unk_12",     8'h12, 5'b00000);
    byte_in("ext_unk_then74", 8'h74, 5'b00000);

    // Timeout: E0 then 8 idle cycles; the 8th produces protoErr.
    byte_in("to_e0",          8'hE0, 5'b00000);
    for (int i = 1; i <= 7; i++) idle("to_wait", 5'b00000);
    idle("to_expire",               5'b00001);
    idle("to_err_end",              5'b00000);
    byte_in("to_then74",      8'h74, 5'b00000);

    // Byte arriving on the expiry cycle wins: processed, no protoErr.
    byte_in("tw_e0",          8'hE0, 5'b00000);
    for (int i = 1; i <= 7; i++) idle("tw_wait", 5'b00000);
    byte_in("tw_right_on_exp", 8'h74, 5'b10000);
    idle("tw_after",                5'b10000);
    byte_in("tw_rel_e0",      8'hE0, 5'b10000);
    byte_in("tw_rel_f0",      8'hF0, 5'b10000);
    byte_in("tw_rel_74",      8'h74, 5'b00000);

    // Illegal bytes after prefixes.
    byte_in("ill_e0",         8'hE0, 5'b00000);
    byte_in("ill_f0",         8'hF0, 5'b00000);
    byte_in("ill_f0_err",     8'hF0, 5'b00001);
    byte_in("ill_idle74",     8'h74, 5'b00000);
    byte_in("ill_brk_f0",     8'hF0, 5'b00000);
    byte_in("ill_brk_e0",     8'hE0, 5'b00001);
    byte_in("ill_idle74b",    8'h74, 5'b00000);
    byte_in("brk_f0f0_a",     8'hF0, 5'b00000);
    byte_in("brk_f0f0_b",     8'hF0, 5'b00000);
    byte_in("brk_f0f0_29",    8'h29, 5'b00000);

    // Reset mid-sequence with leftArrow held.
    byte_in("rst_e0",         8'hE0, 5'b00000);
    byte_in("rst_left",       8'h6B, 5'b01000);
    byte_in("rst_e0_partial", 8'hE0, 5'b01000);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset_async_immediate", outs(), 5'b00000);
    @(posedge clk);
    exp_q.push_back(5'b00000);
    name_q.push_back("reset_held");
    #1;
    reset = 1'b0;
    byte_in("rst_then74",     8'h74, 5'b00000);
    byte_in("rst_space",      8'h29, 5'b00110);

    drive_done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    int waited;
    wait (drive_done);
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
